// File: rtl/stack_arbiter.sv
// Two-requester LIFO stack with round-robin arbitration, combinational grants and registered pop data.
// Optional sticky error flag for ineligible requests is enabled by defining STACK_ERR_EN.
module stack_arbiter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     op0,
    input  logic                     op1,
    input  logic [WIDTH-1:0]         din0,
    input  logic [WIDTH-1:0]         din1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_vld,
    output logic                     dout_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef STACK_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             last_gnt;
    logic             elig0;
    logic             elig1;
    logic             gnt_any;
    logic             gnt_op;
    logic [WIDTH-1:0] gnt_din;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    // Eligibility and round-robin grant; last_gnt=1 means requester 0 is favoured
    always_comb begin
        elig0     = req0 & (op0 ? ~full : ~empty);
        elig1     = req1 & (op1 ? ~full : ~empty);
        gnt0      = ~reset & elig0 & (~elig1 | last_gnt);
        gnt1      = ~reset & elig1 & (~elig0 | ~last_gnt);
        gnt_any   = gnt0 | gnt1;
        gnt_op    = gnt1 ? op1 : op0;
        gnt_din   = gnt1 ? din1 : din0;
        do_push   = gnt_any & gnt_op;
        do_pop    = gnt_any & ~gnt_op;
        wr_idx    = AW'(count);
        top_idx   = AW'(count - CW'(1));
        count_nxt = count;
        if (do_push) begin
            count_nxt = CW'(count + CW'(1));
        end else if (do_pop) begin
            count_nxt = CW'(count - CW'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_id  <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            dout_vld <= do_pop;
            if (do_pop) begin
                dout    <= mem[top_idx];
                dout_id <= gnt1;
            end
            if (gnt_any) begin
                last_gnt <= gnt1;
            end
        end
    end

    // Storage is not reset; occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= gnt_din;
        end
    end

`ifdef STACK_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((req0 & ~elig0) | (req1 & ~elig1)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stack_arbiter;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;

    logic             clk;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [WIDTH-1:0] din0 = '0, din1 = '0;
    logic             gnt0, gnt1, dout_vld, dout_id, full, empty;
    logic [WIDTH-1:0] dout;
    logic [$clog2(DEPTH):0] count;
`ifdef STACK_ERR_EN
    logic             err;
`endif

    int checks = 0;
    int errors = 0;

    stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .dout(dout), .dout_vld(dout_vld), .dout_id(dout_id),
        .count(count), .full(full), .empty(empty)
`ifdef STACK_ERR_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue as the stack and an integer for who won last
    logic [WIDTH-1:0] m_stk [$];
    int               m_last = 1;
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_vld = 1'b0;
    bit               m_id = 1'b0;
    bit               m_err = 1'b0;

    function automatic bit m_elig(input bit r, input bit o);
        return r && (o ? (m_stk.size() < DEPTH) : (m_stk.size() > 0));
    endfunction

    function automatic int exp_winner();
        bit e0;
        bit e1;
        e0 = m_elig(req0, op0);
        e1 = m_elig(req1, op1);
        if (reset) return -1;
        if (e0 && e1) return (m_last == 0) ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int w;
        bit o;
        if (reset) begin
            m_stk.delete();
            m_last = 1;
            m_dout = '0;
            m_vld  = 1'b0;
            m_id   = 1'b0;
            m_err  = 1'b0;
        end else begin
            w = exp_winner();
            if ((req0 && !m_elig(req0, op0)) || (req1 && !m_elig(req1, op1))) m_err = 1'b1;
            m_vld = 1'b0;
            if (w >= 0) begin
                o = (w == 1) ? op1 : op0;
                if (o) begin
                    m_stk.push_back((w == 1) ? din1 : din0);
                end else begin
                    m_dout = m_stk.pop_back();
                    m_vld  = 1'b1;
                    m_id   = 1'(w);
                end
                m_last = w;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin : compare
        int w;
        w = exp_winner();
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        chk("count", 32'(count), 32'(m_stk.size()));
        chk("full", 32'(full), 32'(m_stk.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_stk.size() == 0));
        chk("dout_vld", 32'(dout_vld), 32'(m_vld));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_id", 32'(dout_id), 32'(m_id));
`ifdef STACK_ERR_EN
        chk("err", 32'(err), 32'(m_err));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input bit r, input bit o, input logic [WIDTH-1:0] d);
        if (id == 0) begin
            req0 = r; op0 = o; din0 = d;
        end else begin
            req1 = r; op1 = o; din1 = d;
        end
    endtask

    // Hold a request until granted, with a bounded wait
    task automatic req_op(input int id, input bit o, input logic [WIDTH-1:0] d);
        bit got;
        got = 1'b0;
        drive(id, 1'b1, o, d);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: requester %0d got no grant within 20 cycles", id);
        end
        step();
        drive(id, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, with a request present that must not be granted
        drive(0, 1'b1, 1'b1, 4'h7);
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        drive(0, 1'b0, 1'b0, '0);
        step();
        reset = 1'b0;

        // Two pushes by requester 0, pop by requester 1
        drive(0, 1'b1, 1'b1, 4'h3);
        @(negedge clk);
        chk("p1_gnt0", 32'(gnt0), 32'd1);
        step();
        din0 = 4'h5;
        @(negedge clk);
        chk("p2_gnt0", 32'(gnt0), 32'd1);
        step();
        drive(0, 1'b0, 1'b0, '0);
        chk("p2_count", 32'(count), 32'd2);
        drive(1, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("pop_gnt1", 32'(gnt1), 32'd1);
        step();
        drive(1, 1'b0, 1'b0, '0);
        chk("pop_dout", 32'(dout), 32'h5);
        chk("pop_id", 32'(dout_id), 32'd1);
        chk("pop_vld", 32'(dout_vld), 32'd1);
        step();
        chk("hold_vld", 32'(dout_vld), 32'd0);
        chk("hold_dout", 32'(dout), 32'h5);

        // Simultaneous pushes from empty: requester 0 first, then LIFO pops
        do_reset();
        drive(0, 1'b1, 1'b1, 4'hA);
        drive(1, 1'b1, 1'b1, 4'hB);
        @(negedge clk);
        chk("both_gnt0", 32'(gnt0), 32'd1);
        chk("both_gnt1", 32'(gnt1), 32'd0);
        step();
        drive(0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("second_gnt1", 32'(gnt1), 32'd1);
        step();
        drive(1, 1'b0, 1'b0, '0);
        req_op(0, 1'b0, '0);
        chk("lifo_first", 32'(dout), 32'hB);
        req_op(0, 1'b0, '0);
        chk("lifo_second", 32'(dout), 32'hA);
        chk("lifo_empty", 32'(empty), 32'd1);

        // Pop on empty stalls and flags the error
        drive(1, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("empty_pop_gnt1", 32'(gnt1), 32'd0);
        step();
        drive(1, 1'b0, 1'b0, '0);
        chk("empty_still", 32'(empty), 32'd1);
`ifdef STACK_ERR_EN
        chk("err_set", 32'(err), 32'd1);
`endif
        step();
        step();
`ifdef STACK_ERR_EN
        chk("err_sticky", 32'(err), 32'd1);
`endif

        // Fill, then a stalled push is released by a pop on the other requester
        for (int i = 0; i < 8; i++) req_op(0, 1'b1, 4'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        drive(0, 1'b1, 1'b1, 4'h9);
        drive(1, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("full_gnt0", 32'(gnt0), 32'd0);
        chk("full_gnt1", 32'(gnt1), 32'd1);
        step();
        drive(1, 1'b0, 1'b0, '0);
        chk("unblock_dout", 32'(dout), 32'h7);
        chk("unblock_full", 32'(full), 32'd0);
        @(negedge clk);
        chk("unblock_gnt0", 32'(gnt0), 32'd1);
        step();
        drive(0, 1'b0, 1'b0, '0);
        chk("refill_count", 32'(count), 32'd8);
        chk("refill_full", 32'(full), 32'd1);

        // Four entries, both requesters pop: grants alternate then both stall
        do_reset();
        req_op(0, 1'b1, 4'hA);
        req_op(0, 1'b1, 4'hB);
        req_op(0, 1'b1, 4'hC);
        req_op(1, 1'b1, 4'hD);
        drive(0, 1'b1, 1'b0, '0);
        drive(1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            chk("alt_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            step();
            chk("alt_dout", 32'(dout), 32'(4'hD - 4'(i)));
            chk("alt_id", 32'(dout_id), 32'(i % 2));
        end
        @(negedge clk);
        chk("drain_gnt0", 32'(gnt0), 32'd0);
        chk("drain_gnt1", 32'(gnt1), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        step();
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);

        // Asynchronous reset mid-cycle with count=3, pending push and a live pop pulse
        do_reset();
        for (int i = 1; i <= 4; i++) req_op(0, 1'b1, 4'(i));
        req_op(1, 1'b0, '0);
        chk("pre_count", 32'(count), 32'd3);
        chk("pre_vld", 32'(dout_vld), 32'd1);
        drive(0, 1'b1, 1'b1, 4'h5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_vld", 32'(dout_vld), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_gnt0", 32'(gnt0), 32'd0);
        step();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0);
        chk("arst_nocommit", 32'(count), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, at least 2).
REQ-002 SHALL have parameter WIDTH, default 4, data bits per entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  requester 0/1 operation request, held until granted.
REQ-006 SHALL have ports op0/op1  input  1  requested operation: 1 = push, 0 = pop.
REQ-007 SHALL have ports din0/din1  input  WIDTH  push data, held stable with the request.
REQ-008 SHALL have ports gnt0/gnt1  output  1  combinational grant; the operation commits at the clock edge where grant is 1.
REQ-009 SHALL have port dout  output  WIDTH  registered pop data.
REQ-010 SHALL have port dout_vld  output  1  one-cycle pulse marking valid dout.
REQ-011 SHALL have port dout_id  output  1  index of the requester that owns dout.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have ports full/empty  output  1  count==DEPTH / count==0.
REQ-014 SHALL have port err  output  1  sticky error flag, present only under STACK_ERR_EN.

Function
REQ-015 SHALL store entries in internal storage of DEPTH x WIDTH registers; LIFO order.
REQ-016 SHALL treat a request as eligible when it is a push with full=0, or a pop with empty=0.
REQ-017 SHALL grant at most one requester per cycle; gnt0 and gnt1 never both 1.
REQ-018 SHALL grant the single eligible requester when only one is eligible, regardless of history.
REQ-019 SHALL, when both are eligible, grant the requester not granted most recently (round robin); last-grant pointer updates only on a grant.
REQ-020 SHALL not grant an ineligible request; the request stalls until it becomes eligible.
REQ-021 SHALL, on a granted push, write din to entry[count] and increment count at that edge.
REQ-022 SHALL, on a granted pop, load dout with entry[count-1], decrement count, set dout_id, and pulse dout_vld in the following cycle (latency 1).
REQ-023 SHALL hold dout and dout_id between pops; dout_vld is 0 in any cycle not following a pop.
REQ-024 SHALL let a pop on one requester unblock a stalled push on the other at the next edge (full cleared).

Reset
REQ-025 SHALL, while reset=1, asynchronously force count=0, empty=1, full=0, dout=0, dout_vld=0, dout_id=0, err=0, and last-grant pointer=1 (requester 0 wins first).
REQ-026 SHALL force gnt0=gnt1=0 while reset=1; reset mid-operation aborts that operation with no commit; storage contents need not be cleared.

Configuration
REQ-027 SHALL, with macro STACK_ERR_EN defined, provide err: set on any edge with req=1 and the request ineligible (push on full, pop on empty); err is cleared only by reset.
REQ-028 SHALL, without STACK_ERR_EN, omit the err port and logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then req0 push 4'h3 then 4'h5 -> gnt0 on each, count=2; req1 pop -> next cycle dout=4'h5, dout_id=1, dout_vld=1.
REQ-030 SHALL cover: from empty, req0 push 4'hA and req1 push 4'hB together -> gnt0 first, gnt1 next cycle; two pops return 4'hB then 4'hA.
REQ-031 SHALL cover: 8 pushes -> full=1; req0 push 4'h9 stalls (gnt0=0); req1 pop the same cycle -> gnt1, then gnt0 next cycle, count=8.
REQ-032 SHALL cover: pop request on empty -> no grant, empty=1; with STACK_ERR_EN, err=1 and stays 1 until reset.
REQ-033 SHALL cover: count=4, both holding pop requests -> grants alternate 0,1,0,1, then both stall with empty=1.
REQ-034 SHALL cover: reset asserted mid-clock with count=3 and a push pending -> count=0, dout_vld=0, gnt=0 immediately, without waiting for a clock edge.
